// File: rtl/ysyx_041461_axi_master_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_041461_axi_master_pkg
// Shared definitions for the single-beat AXI4 master:
//   - FSM state encoding
//   - AXI response codes (OKAY/EXOKAY/SLVERR/DECERR)
//   - burst type INCR and transfer size for 64-bit beats
// ----------------------------------------------------------------------------
package ysyx_041461_axi_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RADDR = 3'd1,
        ST_RDATA = 3'd2,
        ST_WREQ  = 3'd3,
        ST_WRESP = 3'd4,
        ST_DONE  = 3'd5
    } axi_state_t;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [2:0] AXI_SIZE_64B    = 3'b011;

endpackage

// File: rtl/ysyx_041461_axi_master.sv
// ----------------------------------------------------------------------------
// ysyx_041461_axi_master
// Bridges a simple CPU request/response handshake onto AXI4 with exactly one
// single-beat (64-bit, INCR, len 0) transaction outstanding at a time.
//
// Parameters:
//   AXI_ID       ID driven on awid/arid
// Ports:
//   clk, rst     clock (rising edge), asynchronous active-low reset
//   req_*        CPU request: valid/ready, wen (1=write), addr, wdata, wstrb
//   resp_*       CPU response: valid/ready, rdata, err
//   aw*/w*/b*    AXI4 write address / write data / write response channels
//   ar*/r*       AXI4 read address / read data channels
//
// Build option:
//   YSYX_041461_AXI_MASTER_IDCHK_EN  when defined, an rid/bid that differs
//   from AXI_ID on the accepting beat forces resp_err; otherwise rid/bid are
//   ignored.
// ----------------------------------------------------------------------------
module ysyx_041461_axi_master
    import ysyx_041461_axi_master_pkg::*;
#(
    parameter logic [3:0] AXI_ID = 4'd0
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wstrb,

    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,

    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,

    output logic        wvalid,
    input  logic        wready,
    output logic [63:0] wdata,
    output logic [7:0]  wstrb,
    output logic        wlast,

    input  logic        bvalid,
    output logic        bready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,

    output logic        arvalid,
    input  logic        arready,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,

    input  logic        rvalid,
    output logic        rready,
    input  logic [3:0]  rid,
    input  logic [1:0]  rresp,
    input  logic [63:0] rdata,
    input  logic        rlast
);

    axi_state_t  state;
    axi_state_t  state_next;

    logic [31:0] addr_q;
    logic [63:0] wdata_q;
    logic [7:0]  wstrb_q;
    logic        aw_done;
    logic        w_done;

    logic        req_fire;
    logic        aw_fire;
    logic        w_fire;
    logic        aw_fin;
    logic        w_fin;
    logic        rd_err;
    logic        wr_err;

    // Single-beat transactions only: rlast carries no information here.
    logic        unused_inputs;
`ifdef YSYX_041461_AXI_MASTER_IDCHK_EN
    assign unused_inputs = &{1'b0, rlast};
`else
    assign unused_inputs = &{1'b0, rlast, rid, bid};
`endif

    // Constant request fields.
    assign awid    = AXI_ID;
    assign arid    = AXI_ID;
    assign awlen   = 8'd0;
    assign arlen   = 8'd0;
    assign awsize  = AXI_SIZE_64B;
    assign arsize  = AXI_SIZE_64B;
    assign awburst = AXI_BURST_INCR;
    assign arburst = AXI_BURST_INCR;
    assign wlast   = 1'b1;

    assign awaddr  = addr_q;
    assign araddr  = addr_q;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;

    // Handshake signals are pure decodes of the state/flag flops, so an
    // asynchronous reset drops them immediately.
    assign req_ready  = (state == ST_IDLE);
    assign resp_valid = (state == ST_DONE);
    assign arvalid    = (state == ST_RADDR);
    assign rready     = (state == ST_RDATA);
    assign bready     = (state == ST_WRESP);
    assign awvalid    = (state == ST_WREQ) && !aw_done;
    assign wvalid     = (state == ST_WREQ) && !w_done;

    assign req_fire = req_valid && req_ready;
    assign aw_fire  = awvalid && awready;
    assign w_fire   = wvalid && wready;

    // A channel counts as finished if it completed earlier or completes now,
    // which covers both handshakes landing in the same cycle.
    assign aw_fin = aw_done || aw_fire;
    assign w_fin  = w_done || w_fire;

`ifdef YSYX_041461_AXI_MASTER_IDCHK_EN
    assign rd_err = (rresp != AXI_RESP_OKAY) || (rid != AXI_ID);
    assign wr_err = (bresp != AXI_RESP_OKAY) || (bid != AXI_ID);
`else
    assign rd_err = (rresp != AXI_RESP_OKAY);
    assign wr_err = (bresp != AXI_RESP_OKAY);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (req_valid)         state_next = req_wen ? ST_WREQ : ST_RADDR;
            ST_RADDR: if (arready)           state_next = ST_RDATA;
            ST_RDATA: if (rvalid)            state_next = ST_DONE;
            ST_WREQ:  if (aw_fin && w_fin)   state_next = ST_WRESP;
            ST_WRESP: if (bvalid)            state_next = ST_DONE;
            ST_DONE:  if (resp_ready)        state_next = ST_IDLE;
            default:                         state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q     <= 32'd0;
            wdata_q    <= 64'd0;
            wstrb_q    <= 8'd0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            resp_rdata <= 64'd0;
            resp_err   <= 1'b0;
        end else begin
            if (req_fire) begin
                addr_q     <= req_addr;
                wdata_q    <= req_wdata;
                wstrb_q    <= req_wstrb;
                aw_done    <= 1'b0;
                w_done     <= 1'b0;
                resp_rdata <= 64'd0;
                resp_err   <= 1'b0;
            end
            if (aw_fire) begin
                aw_done <= 1'b1;
            end
            if (w_fire) begin
                w_done <= 1'b1;
            end
            if ((state == ST_RDATA) && rvalid) begin
                resp_rdata <= rdata;
                resp_err   <= rd_err;
            end
            // Writes report zero data.
            if ((state == ST_WRESP) && bvalid) begin
                resp_rdata <= 64'd0;
                resp_err   <= wr_err;
            end
        end
    end

endmodule
